// File: rtl/multi_one_shot_if.sv
//==============================================================================
// multi_one_shot_if: per-channel level inputs, arm enables and pulse outputs
// Rev 1.0
//==============================================================================
`default_nettype none

interface multi_one_shot_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] x;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] y;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] miss;

  modport master (
    output x,
    output en,
    input  y,
    input  busy,
    input  miss
  );

  modport slave (
    input  x,
    input  en,
    output y,
    output busy,
    output miss
  );
endinterface

`default_nettype wire

// File: rtl/multi_one_shot.sv
//==============================================================================
// multi_one_shot: N-channel edge-triggered one-shot with retrigger and lockout
// Rev 1.0
//==============================================================================
`default_nettype none

module multi_one_shot #(
  parameter int N_CH      = 4,
  parameter int PULSE_W   = 1,
  parameter int LOCKOUT   = 0,
  parameter int EDGE_MODE = 0,
  parameter int RETRIG    = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  multi_one_shot_if.slave  s_if
);

  localparam int c_MAXV  = (PULSE_W > LOCKOUT) ? PULSE_W : LOCKOUT;
  localparam int c_CNT_W = $clog2(c_MAXV + 1);

  localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_W - 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LD  = (LOCKOUT > 0) ? c_CNT_W'(LOCKOUT - 1) : '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  logic [N_CH-1:0] w_y;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_miss;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_xq;
    logic               r_y;
    logic               r_miss;
    logic               w_miss_nxt;
    logic               w_rise;
    logic               w_fall;
    logic               w_edge;

    assign w_rise = s_if.x[g] & ~r_xq;
    assign w_fall = ~s_if.x[g] & r_xq;
    assign w_edge = (EDGE_MODE == 1) ? w_fall :
                    (EDGE_MODE == 2) ? (w_rise | w_fall) : w_rise;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_xq    <= 1'b0;
        r_y     <= 1'b0;
        r_miss  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_xq    <= s_if.x[g];
        // y follows the registered state, so it trails busy by one cycle
        r_y     <= (r_state == S_PULSE);
        r_miss  <= w_miss_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_miss_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge && s_if.en[g]) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = c_PULSE_LD;
          end
        end
        S_PULSE: begin
          if (w_edge && (RETRIG != 0)) begin
            w_cnt_nxt = c_PULSE_LD;
          end else begin
            w_miss_nxt = w_edge;
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - c_CNT_ONE;
            end else if (LOCKOUT > 0) begin
              w_state_nxt = S_LOCK;
              w_cnt_nxt   = c_LOCK_LD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_LOCK: begin
          // an edge on the exit cycle is still swallowed
          w_miss_nxt = w_edge;
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_y[g]    = r_y;
    assign w_busy[g] = (r_state != S_IDLE);
    assign w_miss[g] = r_miss;
  end

  assign s_if.y    = w_y;
  assign s_if.busy = w_busy;
  assign s_if.miss = w_miss;

endmodule

`default_nettype wire
